// File: rtl/alu_mc.sv
// alu_mc: multi-cycle integer ALU; single-cycle logic/arith ops, iterative
// shift-add multiply and restoring divide, EBREAK halt flag.
`timescale 1ns/1ps
module alu_mc #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            word,
  input  logic            ebreak,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            halted
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_DIV  = 4'd11;
  localparam logic [3:0] OP_DIVU = 4'd12;
  localparam logic [3:0] OP_REM  = 4'd13;
  localparam logic [3:0] OP_REMU = 4'd14;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          state;
  logic [SHW-1:0]  cnt;
  logic [XLEN-1:0] p;      // product accumulator / partial remainder
  logic [XLEN-1:0] a_q;    // multiplier / dividend-quotient shift register
  logic [XLEN-1:0] b_q;    // multiplicand / divisor magnitude
  logic [3:0]      op_q;
  logic            word_q;
  logic            neg_q;
  logic            neg_r;

  logic            word_eff;
  logic [31:0]     a32, b32, r32, a_mag32, b_mag32;
  logic [XLEN-1:0] rf, single_c, a_magf, b_magf, dvd_init, dvs_init;
  logic [SHW-1:0]  sh;
  logic [4:0]      sh32;
  logic            is_div, is_sdiv, dz, ovf, a_neg, b_neg, start_iter;

  assign word_eff = (XLEN == 64) && word;

  // Single-cycle result and iterative-operand preparation from the request.
  always_comb begin
    a32     = src1[31:0];
    b32     = src2[31:0];
    sh      = src2[SHW-1:0];
    sh32    = src2[4:0];
    is_div  = op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    is_sdiv = (op == OP_DIV) || (op == OP_REM);
    dz      = word_eff ? (b32 == 32'd0) : (src2 == '0);
    ovf     = is_sdiv && (word_eff ? (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF)
                                   : (src1 == MIN_NEG && src2 == '1));
    start_iter = (op == OP_MUL) || (is_div && !dz && !ovf);
    rf  = '0;
    r32 = '0;
    case (op)
      OP_ADD:  begin rf = src1 + src2; r32 = a32 + b32; end
      OP_SUB:  begin rf = src1 - src2; r32 = a32 - b32; end
      OP_SLL:  begin rf = src1 << sh;  r32 = a32 << sh32; end
      OP_SLT:  begin
        rf  = {{(XLEN-1){1'b0}}, ($signed(src1) < $signed(src2))};
        r32 = {31'd0, ($signed(a32) < $signed(b32))};
      end
      OP_SLTU: begin
        rf  = {{(XLEN-1){1'b0}}, (src1 < src2)};
        r32 = {31'd0, (a32 < b32)};
      end
      OP_XOR:  begin rf = src1 ^ src2; r32 = a32 ^ b32; end
      OP_SRL:  begin rf = src1 >> sh;  r32 = a32 >> sh32; end
      OP_SRA:  begin
        rf  = $unsigned($signed(src1) >>> sh);
        r32 = $unsigned($signed(a32) >>> sh32);
      end
      OP_OR:   begin rf = src1 | src2; r32 = a32 | b32; end
      OP_AND:  begin rf = src1 & src2; r32 = a32 & b32; end
      OP_DIV, OP_DIVU: begin
        rf  = dz ? '1 : src1;
        r32 = dz ? '1 : a32;
      end
      OP_REM, OP_REMU: begin
        rf  = dz ? src1 : '0;
        r32 = dz ? a32 : 32'd0;
      end
      default: begin rf = '0; r32 = '0; end
    endcase
    single_c = word_eff ? XLEN'($signed(r32)) : rf;

    a_neg    = is_sdiv && (word_eff ? a32[31] : src1[XLEN-1]);
    b_neg    = is_sdiv && (word_eff ? b32[31] : src2[XLEN-1]);
    a_mag32  = a_neg ? -a32 : a32;
    b_mag32  = b_neg ? -b32 : b32;
    a_magf   = a_neg ? -src1 : src1;
    b_magf   = b_neg ? -src2 : src2;
    // W dividend sits in the top half so the MSB-first shift sees its bit 31 first
    dvd_init = word_eff ? (XLEN'(a_mag32) << (XLEN - 32)) : a_magf;
    dvs_init = word_eff ? XLEN'(b_mag32) : b_magf;
  end

  logic [XLEN:0]   trial;
  logic            ge;
  logic [XLEN-1:0] p_nx, a_q_nx, b_q_nx, q_fix, r_fix, iter_w, iter_res;

  // One multiply or divide iteration plus final sign fix-up.
  always_comb begin
    trial = {p, a_q[XLEN-1]} - {1'b0, b_q};
    ge    = ~trial[XLEN];
    if (op_q == OP_MUL) begin
      p_nx   = a_q[0] ? (p + b_q) : p;
      a_q_nx = a_q >> 1;
      b_q_nx = b_q << 1;
    end else begin
      p_nx   = ge ? trial[XLEN-1:0] : {p[XLEN-2:0], a_q[XLEN-1]};
      a_q_nx = {a_q[XLEN-2:0], ge};
      b_q_nx = b_q;
    end
    q_fix = neg_q ? -a_q_nx : a_q_nx;
    r_fix = neg_r ? -p_nx : p_nx;
    case (op_q)
      OP_MUL:          iter_w = p_nx;
      OP_DIV, OP_DIVU: iter_w = q_fix;
      default:         iter_w = r_fix;
    endcase
    iter_res = word_q ? XLEN'($signed(iter_w[31:0])) : iter_w;
  end

  // Control FSM with registered handshake outputs and datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      halted    <= 1'b0;
      result    <= '0;
      cnt       <= '0;
      p         <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      word_q    <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            op_q     <= op;
            word_q   <= word_eff;
            in_ready <= 1'b0;
            if (ebreak) begin
              result    <= '0;
              halted    <= 1'b1;
              out_valid <= 1'b1;
              state     <= S_DONE;
            end else if (start_iter) begin
              p     <= '0;
              a_q   <= (op == OP_MUL) ? src2 : dvd_init;
              b_q   <= (op == OP_MUL) ? src1 : dvs_init;
              neg_q <= a_neg ^ b_neg;
              neg_r <= a_neg;
              cnt   <= word_eff ? SHW'(31) : SHW'(XLEN - 1);
              state <= S_BUSY;
            end else begin
              result    <= single_c;
              out_valid <= 1'b1;
              state     <= S_DONE;
            end
          end
        end
        S_BUSY: begin
          p   <= p_nx;
          a_q <= a_q_nx;
          b_q <= b_q_nx;
          cnt <= cnt - SHW'(1);
          if (cnt == '0) begin
            result    <= iter_res;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= ~halted;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed, table-driven checks of alu_mc (XLEN=64) plus
// handshake, EBREAK and reset sequences.
`timescale 1ns/1ps
module tb_alu_mc;

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, SLL = 4'd2, SLT = 4'd3,
                         SLTU = 4'd4, XOR = 4'd5, SRL = 4'd6, SRA = 4'd7,
                         OR = 4'd8, AND = 4'd9, MUL = 4'd10, DIV = 4'd11,
                         DIVU = 4'd12, REM = 4'd13, REMU = 4'd14, RSV = 4'd15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op = '0;
  logic [63:0] src1 = '0;
  logic [63:0] src2 = '0;
  logic        word = 1'b0;
  logic        ebreak = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] result;
  logic        halted;

  int checks = 0;
  int errors = 0;

  alu_mc #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .src1(src1), .src2(src2), .word(word), .ebreak(ebreak),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .halted(halted)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  op;
    logic [63:0] s1;
    logic [63:0] s2;
    logic        w;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b,
                         input logic w, input logic [63:0] e, input int l);
    vec_t v;
    v.op = o; v.s1 = a; v.s2 = b; v.w = w; v.exp = e; v.lat = l;
    vq.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Present one request, wait (bounded) for out_valid; report latency and
  // whether in_ready stayed low while waiting.
  task automatic run_op(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b,
                        input logic w, input logic eb,
                        output logic [63:0] res, output int lat, output logic rdy_low);
    op = o; src1 = a; src2 = b; word = w; ebreak = eb; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; ebreak = 1'b0;
    lat = 1; rdy_low = 1'b1;
    while (!out_valid && lat < 200) begin
      if (in_ready) rdy_low = 1'b0;
      tick();
      lat++;
    end
    if (in_ready) rdy_low = 1'b0;
    res = result;
  endtask

  initial begin
    logic [63:0] res;
    int          lat;
    logic        rdy_low;
    int          seen;

    add_vec(ADD,  64'd5, 64'hFFFF_FFFF_FFFF_FFFD, 0, 64'd2, 1);
    add_vec(SUB,  64'd3, 64'd5, 0, 64'hFFFF_FFFF_FFFF_FFFE, 1);
    add_vec(SLL,  64'd1, 64'h44, 0, 64'h10, 1);
    add_vec(SLL,  64'd1, 64'd63, 0, 64'h8000_0000_0000_0000, 1);
    add_vec(SLT,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 64'd1, 1);
    add_vec(SLTU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 64'd0, 1);
    add_vec(XOR,  64'hF0F0, 64'hFF00, 0, 64'h0FF0, 1);
    add_vec(SRL,  64'h8000_0000_0000_0000, 64'd63, 0, 64'd1, 1);
    add_vec(SRA,  64'h8000_0000_0000_0000, 64'd4, 0, 64'hF800_0000_0000_0000, 1);
    add_vec(OR,   64'hF0, 64'h0F, 0, 64'hFF, 1);
    add_vec(AND,  64'hF0, 64'h3C, 0, 64'h30, 1);
    add_vec(MUL,  64'h1_0000_0001, 64'd3, 0, 64'h3_0000_0003, 65);
    add_vec(MUL,  64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 0, 64'hFFFF_FFFF_FFFF_FFFA, 65);
    add_vec(DIV,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    add_vec(REM,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    add_vec(DIV,  64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 0, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    add_vec(REM,  64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 0, 64'd1, 65);
    add_vec(DIVU, 64'd100, 64'd7, 0, 64'd14, 65);
    add_vec(REMU, 64'd100, 64'd7, 0, 64'd2, 65);
    add_vec(DIVU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    add_vec(DIVU, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'd0, 65);
    add_vec(DIVU, 64'd9, 64'd0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    add_vec(REMU, 64'd9, 64'd0, 0, 64'd9, 1);
    add_vec(DIV,  64'd9, 64'd0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    add_vec(REM,  64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 0, 64'hFFFF_FFFF_FFFF_FFF9, 1);
    add_vec(DIV,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'h8000_0000_0000_0000, 1);
    add_vec(REM,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'd0, 1);
    add_vec(RSV,  64'd1, 64'd2, 0, 64'd0, 1);
    add_vec(ADD,  64'h7FFF_FFFF, 64'd1, 1, 64'hFFFF_FFFF_8000_0000, 1);
    add_vec(SRA,  64'h8000_0000, 64'h24, 1, 64'hFFFF_FFFF_F800_0000, 1);
    add_vec(SRL,  64'hFFFF_FFFF_8000_0000, 64'd31, 1, 64'd1, 1);
    add_vec(SLL,  64'd1, 64'd31, 1, 64'hFFFF_FFFF_8000_0000, 1);
    add_vec(MUL,  64'hABCD_0000_0000_0003, 64'h4000_0000, 1, 64'hFFFF_FFFF_C000_0000, 33);
    add_vec(DIV,  64'h1234_0000_FFFF_FFF9, 64'd2, 1, 64'hFFFF_FFFF_FFFF_FFFD, 33);
    add_vec(REMU, 64'h8000_0005, 64'h10, 1, 64'd5, 33);
    add_vec(DIVU, 64'h8000_0000, 64'd1, 1, 64'hFFFF_FFFF_8000_0000, 33);
    add_vec(DIV,  64'h8000_0000, 64'hFFFF_FFFF, 1, 64'hFFFF_FFFF_8000_0000, 1);
    add_vec(DIVU, 64'd5, 64'h1_0000_0000, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1);

    // Asynchronous reset state, before any clock edge.
    #1;
    chk("rst_state", {61'd0, out_valid, halted, 1'b0}, 64'd0);
    chk("rst_result", result, 64'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

    for (int i = 0; i < vq.size(); i++) begin
      run_op(vq[i].op, vq[i].s1, vq[i].s2, vq[i].w, 1'b0, res, lat, rdy_low);
      chk($sformatf("v%0d_result", i), res, vq[i].exp);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vq[i].lat));
      if (vq[i].lat > 1) chk($sformatf("v%0d_busy_ready", i), {63'd0, rdy_low}, 64'd1);
      tick();
      chk($sformatf("v%0d_drain", i), {62'd0, out_valid, in_ready}, 64'd1);
    end

    // Backpressure: result held 3 cycles; a request offered during the
    // handshake cycle is accepted only on the following cycle.
    out_ready = 1'b0;
    run_op(ADD, 64'd2, 64'd3, 1'b0, 1'b0, res, lat, rdy_low);
    chk("bp_first", res, 64'd5);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("bp_hold%0d", c), {result[61:0], out_valid, in_ready}, {62'd5, 2'b10});
    end
    out_ready = 1'b1;
    op = ADD; src1 = 64'd1; src2 = 64'd1; word = 1'b0; in_valid = 1'b1;
    tick();
    chk("bp_no_bypass", {62'd0, out_valid, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_next_accept", {result[62:0], out_valid}, {63'd2, 1'b1});
    tick();

    // EBREAK: zero result, sticky halt, no further accepts.
    run_op(ADD, 64'd5, 64'd3, 1'b0, 1'b1, res, lat, rdy_low);
    chk("eb_result", res, 64'd0);
    chk("eb_latency", 64'(lat), 64'd1);
    chk("eb_halted", {62'd0, halted, in_ready}, 64'd2);
    tick();
    op = ADD; src1 = 64'd1; src2 = 64'd1; in_valid = 1'b1;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (out_valid || in_ready || !halted) seen++;
    end
    in_valid = 1'b0;
    chk("eb_stays_halted", 64'(seen), 64'd0);
    rst = 1'b1;
    #1;
    chk("eb_rst_clears", {62'd0, halted, out_valid}, 64'd0);
    #2;
    rst = 1'b0;
    tick();
    chk("eb_rst_ready", {63'd0, in_ready}, 64'd1);

    // Reset mid-DIVU aborts with no result.
    op = DIVU; src1 = 64'd1000; src2 = 64'd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    chk("mid_busy", {62'd0, in_ready, out_valid}, 64'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_async", {62'd0, out_valid, halted}, 64'd0);
    #2;
    rst = 1'b0;
    tick();
    chk("mid_rst_ready", {62'd0, in_ready, out_valid}, 64'd2);
    seen = 0;
    for (int c = 0; c < 70; c++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("mid_no_result", 64'(seen), 64'd0);
    run_op(ADD, 64'd40, 64'd2, 1'b0, 1'b0, res, lat, rdy_low);
    chk("post_rst_add", res, 64'd42);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
